// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed seven-segment scan controller.
// One shared 4-bit decoder input is sequenced across NUM_DIGITS digits, with
// one-hot digit enables and an all-off gap between digits.
// Ports: clk, rst_n (async active-low), i_enable (scan/blank),
//   i_load/i_data_in/o_ready (value handshake, swapped in at frame wrap),
//   o_digit_code (decoder input), o_anode (one-hot, active high),
//   o_frame_tick (1-cycle pulse at frame wrap).
// Option: define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_enable,
   input  logic                    i_load,
   input  logic [4*NUM_DIGITS-1:0] i_data_in,
   output logic                    o_ready,
   output logic [3:0]              o_digit_code,
   output logic [NUM_DIGITS-1:0]   o_anode,
   output logic                    o_frame_tick
);

   localparam int DW     = $clog2(REFRESH_DIV);
   localparam int IW     = $clog2(NUM_DIGITS);
   localparam int DATA_W = 4 * NUM_DIGITS;

   localparam logic [DW-1:0] ON_LAST =
      DW'(REFRESH_DIV - GAP_CYCLES - 1);
   localparam logic [DW-1:0] GAP_LAST =
      DW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

   typedef enum logic [1:0] {
      S_OFF,
      S_ON,
      S_GAP
   } state_t;

   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic [DW-1:0]         r_div;
   logic [DATA_W-1:0]     r_shadow;
   logic [DATA_W-1:0]     r_display;
   logic                  r_pending;
   logic                  r_ready;
   logic [NUM_DIGITS-1:0] r_anode;
   logic [3:0]            r_code;
   logic                  r_tick;

   state_t                w_state_nx;
   logic [IW-1:0]         w_idx_nx;
   logic [DW-1:0]         w_div_nx;
   logic                  w_adv;
   logic                  w_wrap;
   logic                  w_xfer;
   logic                  w_accept;
   logic [DATA_W-1:0]     w_disp_nx;
   logic [NUM_DIGITS-1:0] w_anode_nx;
   logic [3:0]            w_code_nx;

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_div_nx   = r_div + 1'b1;
      w_adv      = 1'b0;
      w_wrap     = 1'b0;
      if (!i_enable) begin
         w_state_nx = S_OFF;
         w_idx_nx   = '0;
         w_div_nx   = '0;
      end else begin
         unique case (r_state)
            S_OFF: begin
               w_state_nx = S_ON;
               w_idx_nx   = '0;
               w_div_nx   = '0;
            end
            S_ON: begin
               if (r_div == ON_LAST) begin
                  w_div_nx = '0;
                  if (GAP_CYCLES == 0) begin
                     w_state_nx = S_ON;
                     w_adv      = 1'b1;
                  end else begin
                     w_state_nx = S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (r_div == GAP_LAST) begin
                  w_state_nx = S_ON;
                  w_div_nx   = '0;
                  w_adv      = 1'b1;
               end
            end
            default: begin
               w_state_nx = S_OFF;
               w_idx_nx   = '0;
               w_div_nx   = '0;
            end
         endcase
         if (w_adv) begin
            if (r_idx == IDX_LAST) begin
               w_idx_nx = '0;
               w_wrap   = 1'b1;
            end else begin
               w_idx_nx = r_idx + 1'b1;
            end
         end
      end

      // Pending value lands at a frame wrap, on disable, or whenever idle.
      w_xfer    = r_pending &&
                  (w_wrap || !i_enable || (r_state == S_OFF));
      w_accept  = i_load && r_ready;
      // New digit 0 must already show the swapped-in value.
      w_disp_nx = w_xfer ? r_shadow : r_display;

      w_code_nx  = r_code;
      w_anode_nx = '0;
      if (w_state_nx == S_ON) begin
         w_code_nx  = w_disp_nx[4*w_idx_nx +: 4];
         w_anode_nx = ONE << w_idx_nx;
`ifdef SEG7_LZ_BLANK_EN
         // Dark if this nibble and every higher nibble are zero.
         if ((w_idx_nx != '0) &&
             ((w_disp_nx >> (4 * w_idx_nx)) == '0))
            w_anode_nx = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_OFF;
         r_idx     <= '0;
         r_div     <= '0;
         r_shadow  <= '0;
         r_display <= '0;
         r_pending <= 1'b0;
         r_ready   <= 1'b1;
         r_anode   <= '0;
         r_code    <= '0;
         r_tick    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_div   <= w_div_nx;
         r_anode <= w_anode_nx;
         r_code  <= w_code_nx;
         r_tick  <= w_wrap;
         if (w_accept) begin
            r_shadow  <= i_data_in;
            r_pending <= 1'b1;
            r_ready   <= 1'b0;
         end else if (w_xfer) begin
            r_display <= r_shadow;
            r_pending <= 1'b0;
         end else if (!r_pending && !r_ready) begin
            r_ready <= 1'b1;
         end
      end
   end

   assign o_ready      = r_ready;
   assign o_digit_code = r_code;
   assign o_anode      = r_anode;
   assign o_frame_tick = r_tick;

endmodule
